// File: rtl/qpu_timing_queue_if.sv
// Push/release bus of the timing-control queue.
//   i_valid, i_interval, i_op : push side, driven by the decoder (master)
//   o_ready                   : push accepted this cycle (queue not full)
//   o_op_valid, o_op,
//   o_timestamp               : release strobe and payload toward pulse generation
interface qpu_timing_queue_if #(
  parameter int unsigned TIME_W = 20,
  parameter int unsigned OP_W   = 32,
  parameter int unsigned TS_W   = 32
) ();

  logic              i_valid;
  logic              o_ready;
  logic [TIME_W-1:0] i_interval;
  logic [OP_W-1:0]   i_op;
  logic              o_op_valid;
  logic [OP_W-1:0]   o_op;
  logic [TS_W-1:0]   o_timestamp;

  modport master (
    output i_valid, i_interval, i_op,
    input  o_ready, o_op_valid, o_op, o_timestamp
  );

  modport slave (
    input  i_valid, i_interval, i_op,
    output o_ready, o_op_valid, o_op, o_timestamp
  );

endinterface

// File: rtl/qpu_timing_queue.sv
// Timing-control queue: buffers decoded operations with their wait interval and
// releases each one exactly max(interval,1) cycles after the previous release
// (or after start), flagging any entry that leaves later than its interval.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_start      : begin the timeline (only from IDLE)
//   i_clear      : flush the queue and return to IDLE (highest priority)
//   bus          : push handshake and release strobe/payload/timestamp
//   o_busy       : timeline running
//   o_empty, o_full, o_count : occupancy status
//   o_underrun   : sticky late-release flag
module qpu_timing_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TIME_W = 20,
  parameter int unsigned OP_W   = 32,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_clear,
  qpu_timing_queue_if.slave   bus,
  output logic                o_busy,
  output logic                o_empty,
  output logic                o_full,
  output logic [CNT_W-1:0]    o_count,
  output logic                o_underrun
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [TIME_W-1:0] interval;
    logic [OP_W-1:0]   op;
  } entry_t;

  state_t            state_q, state_d;
  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [TIME_W-1:0] elapsed_q;
  logic [TS_W-1:0]   tstamp_q;
  logic              underrun_q;

  entry_t            head;
  logic [TIME_W-1:0] head_int;
  logic              full;
  logic              push;
  logic              release_op;
  logic              late;
  logic              start_run;

  assign head     = mem[rd_ptr_q];
  // A zero interval means "next cycle", same as one.
  assign head_int = (head.interval == '0) ? TIME_W'(1) : head.interval;
  assign full     = (count_q == CNT_W'(DEPTH));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus release/push decisions; all depend on registers except push/start.
  always_comb begin
    state_d    = state_q;
    release_op = 1'b0;
    late       = 1'b0;
    start_run  = 1'b0;
    push       = bus.i_valid && !full && !i_clear;
    if (state_q == S_RUN && count_q != '0 && elapsed_q >= head_int) begin
      release_op = 1'b1;
      late       = (elapsed_q > head_int);
    end
    if (i_clear) begin
      state_d = S_IDLE;
    end else if (state_q == S_IDLE && i_start) begin
      state_d   = S_RUN;
      start_run = 1'b1;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{interval: bus.i_interval, op: bus.i_op};
    end
  end

  // Pointers, occupancy, elapsed/timestamp counters and sticky underrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      elapsed_q  <= '0;
      tstamp_q   <= '0;
      underrun_q <= 1'b0;
    end else if (i_clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      elapsed_q  <= '0;
      tstamp_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (release_op) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, release_op})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (start_run) begin
        elapsed_q  <= TIME_W'(1);
        tstamp_q   <= TS_W'(1);
        underrun_q <= 1'b0;
      end else if (state_q == S_RUN) begin
        tstamp_q <= tstamp_q + TS_W'(1);
        if (release_op) begin
          elapsed_q <= TIME_W'(1);
        end else if (elapsed_q != '1) begin
          elapsed_q <= elapsed_q + TIME_W'(1);
        end
        if (late) begin
          underrun_q <= 1'b1;
        end
      end
    end
  end

  // Release outputs are zeroed whenever no operation is leaving.
  assign bus.o_op_valid  = release_op;
  assign bus.o_op        = release_op ? head.op : '0;
  assign bus.o_timestamp = release_op ? tstamp_q : '0;
  assign bus.o_ready     = !full;

  assign o_busy     = (state_q == S_RUN);
  assign o_empty    = (count_q == '0);
  assign o_full     = full;
  assign o_count    = count_q;
  assign o_underrun = underrun_q;

endmodule
